// File: rtl/cte_scheduler.sv
// Group-granular arbiter sharing one colour-transform engine between a YUV->RGB
// byte stream (requester 0) and an RGB->YUV pixel stream (requester 1).
module cte_scheduler #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [23:0] req1_data,
    output logic        cte_op_mode,
    output logic        cte_in_en,
    output logic [7:0]  cte_yuv_in,
    output logic [23:0] cte_rgb_in,
    input  logic        cte_busy,
    input  logic        cte_out_valid,
    input  logic [23:0] cte_rgb_out,
    input  logic [7:0]  cte_yuv_out,
    output logic        out0_valid,
    output logic [23:0] out0_data,
    output logic        out1_valid,
    output logic [7:0]  out1_data,
    output logic        grp_done,
    output logic        err_timeout
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_grant, r_last_grant, r_op_mode;
    logic [2:0]      r_in_cnt, r_out_cnt;
    logic [WD_W-1:0] r_wd;
    logic            r_err;
    logic            r_out0_valid, r_out1_valid, r_grp_done;
    logic [23:0]     r_out0_data;
    logic [7:0]      r_out1_data;

    logic            w_active, w_gvalid, w_in_en, w_out_hit;
    logic            w_req_any, w_new_grant;
    logic [2:0]      w_in_exp, w_out_exp, w_in_cnt_nxt, w_out_cnt_nxt;
    logic [WD_W-1:0] w_wd_inc;
    logic            w_wd_expire, w_grp_complete;

    assign w_active      = (r_state != IDLE);
    assign w_gvalid      = r_grant ? req1_valid : req0_valid;
    assign w_in_en       = (r_state == ISSUE) && w_gvalid && !cte_busy;
    // Engine results outside a granted group belong to nobody and are dropped.
    assign w_out_hit     = w_active && cte_out_valid;
    assign w_in_exp      = r_grant ? 3'd2 : 3'd4;
    assign w_out_exp     = r_grant ? 3'd4 : 3'd2;
    assign w_in_cnt_nxt  = r_in_cnt + 3'd1;
    assign w_out_cnt_nxt = r_out_cnt + {2'b00, w_out_hit};
    assign w_wd_inc      = r_wd + {{(WD_W-1){1'b0}}, 1'b1};
    assign w_wd_expire   = w_active && !w_in_en && !cte_out_valid &&
                           (w_wd_inc == WD_W'(TIMEOUT));
    assign w_grp_complete = (r_state == DRAIN) && (w_out_cnt_nxt >= w_out_exp);
    assign w_req_any     = req0_valid || req1_valid;
    assign w_new_grant   = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        cte_in_en   = 1'b0;
        cte_yuv_in  = 8'h00;
        cte_rgb_in  = 24'h000000;
        case (r_state)
            IDLE: begin
                if (w_req_any) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                cte_in_en  = w_in_en;
                req0_ready = w_in_en && !r_grant;
                req1_ready = w_in_en && r_grant;
                if (r_grant) cte_rgb_in = req1_data;
                else         cte_yuv_in = req0_data;
                if (w_wd_expire)                             w_state_nxt = IDLE;
                else if (w_in_en && w_in_cnt_nxt == w_in_exp) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_grp_complete || w_wd_expire) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_op_mode    <= 1'b0;
            r_in_cnt     <= 3'd0;
            r_out_cnt    <= 3'd0;
            r_wd         <= '0;
            r_err        <= 1'b0;
            r_out0_valid <= 1'b0;
            r_out1_valid <= 1'b0;
            r_out0_data  <= 24'h000000;
            r_out1_data  <= 8'h00;
            r_grp_done   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grp_done   <= w_grp_complete;
            r_out0_valid <= w_out_hit && !r_grant;
            r_out1_valid <= w_out_hit && r_grant;
            if (w_out_hit && !r_grant) r_out0_data <= cte_rgb_out;
            if (w_out_hit && r_grant)  r_out1_data <= cte_yuv_out;
            if (r_state == IDLE) begin
                // Mode only moves here, so it is frozen for the whole group.
                if (w_req_any) begin
                    r_grant   <= w_new_grant;
                    r_op_mode <= w_new_grant;
                    r_in_cnt  <= 3'd0;
                    r_out_cnt <= 3'd0;
                    r_wd      <= '0;
                end
            end else begin
                if (w_in_en) r_in_cnt <= w_in_cnt_nxt;
                r_out_cnt <= w_out_cnt_nxt;
                r_wd      <= (w_in_en || cte_out_valid) ? '0 : w_wd_inc;
                if (w_wd_expire) r_err <= 1'b1;
                if (w_grp_complete || w_wd_expire) r_last_grant <= r_grant;
            end
        end
    end

    assign cte_op_mode = r_op_mode;
    assign out0_valid  = r_out0_valid;
    assign out0_data   = r_out0_data;
    assign out1_valid  = r_out1_valid;
    assign out1_data   = r_out1_data;
    assign grp_done    = r_grp_done;
    assign err_timeout = r_err;
endmodule

// File: doc/cte_scheduler.md
CTE_SCHEDULER -- requirements
Module: cte_scheduler

Interface
REQ-001 Parameter: TIMEOUT, default 16, idle cycles tolerated inside a granted group before abort.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 req0_valid / req0_ready / req0_data  input / output / input  1/1/8  YUV->RGB requester byte stream in U,Y,V,Y order.
REQ-005 req1_valid / req1_ready / req1_data  input / output / input  1/1/24  RGB->YUV requester pixel stream, {R,G,B}.
REQ-006 cte_op_mode  output  1  engine mode: 0 = YUV->RGB, 1 = RGB->YUV.
REQ-007 cte_in_en / cte_yuv_in / cte_rgb_in  output  1/8/24  engine input strobe and data.
REQ-008 cte_busy / cte_out_valid  input  1/1  engine status.
REQ-009 cte_rgb_out / cte_yuv_out  input  24/8  engine results.
REQ-010 out0_valid / out0_data  output  1/24  RGB results returned to requester 0.
REQ-011 out1_valid / out1_data  output  1/8  YUV bytes returned to requester 1.
REQ-012 grp_done  output  1  one-cycle pulse when a group completes.
REQ-013 err_timeout  output  1  sticky timeout flag.

Function
REQ-014 The scheduler SHALL share the engine between the two requesters at group granularity: group0 = 4 input bytes -> 2 RGB results; group1 = 2 input pixels -> 4 YUV bytes.
REQ-015 FSM states: IDLE, ISSUE, DRAIN.
REQ-016 IDLE: if only one reqN_valid is high, grant N; if both are high, grant the requester not granted last (round-robin, last_grant resets to 1 so requester 0 wins the first tie); register grant and cte_op_mode = grant; clear in_cnt, out_cnt; go to ISSUE next cycle.
REQ-017 cte_op_mode SHALL change only in IDLE and SHALL remain stable from ISSUE entry until return to IDLE.
REQ-018 ISSUE: cte_in_en = reqG_valid AND NOT cte_busy (combinational); reqG_ready = cte_in_en; the non-granted ready is 0.
REQ-019 cte_yuv_in = req0_data and cte_rgb_in = req1_data, passed combinationally; the unused bus is driven 0.
REQ-020 in_cnt increments on each cte_in_en; on the transfer that completes the group's input count (4 or 2), the FSM goes to DRAIN.
REQ-021 out_cnt increments on each cte_out_valid in ISSUE or DRAIN; results arriving during ISSUE SHALL be counted.
REQ-022 DRAIN: no cte_in_en; when out_cnt reaches the expected count (2 or 4), pulse grp_done, update last_grant = grant, and go to IDLE.
REQ-023 Result return: on cte_out_valid, register out0_data = cte_rgb_out with out0_valid = 1 if grant = 0, otherwise out1_data = cte_yuv_out with out1_valid = 1; one-cycle latency; valids are single-cycle.
REQ-024 A granted requester that drops valid mid-group SHALL keep the grant; no switch occurs until the group completes.
REQ-025 Watchdog: in ISSUE/DRAIN, a counter clears on any cte_in_en or cte_out_valid, otherwise increments. At count = TIMEOUT, set err_timeout, abandon the group without pulsing grp_done, go to IDLE, and update last_grant.
REQ-026 cte_out_valid in IDLE SHALL be ignored: not counted and not forwarded.
REQ-027 Counters SHALL be sized for their maxima: 3-bit in_cnt/out_cnt; watchdog width ceil(log2(TIMEOUT+1)).

Reset
REQ-028 While reset = 0 at a clock edge: state = IDLE, last_grant = 1, all counters 0, err_timeout = 0. Registered outputs (out*_valid, out*_data, grp_done) = 0, cte_op_mode = 0. Combinational outputs cte_in_en, req*_ready, cte_yuv_in and cte_rgb_in = 0 while state = IDLE.
REQ-029 Reset asserted mid-group SHALL discard the group; no grp_done and no further out*_valid.

Verification
REQ-030 Only req0 valid with bytes 0x80,0x10,0x80,0x20; engine returns 2 results -> 4 in_en, then out0_valid twice with the engine data, grp_done once, op_mode held 0.
REQ-031 Both requesters valid continuously after reset -> grant order 0,1,0,1; op_mode toggles only between groups; grp_done after each group.
REQ-032 cte_busy held high 3 cycles during ISSUE -> no in_en and no ready during those cycles; no data lost; in_cnt unchanged.
REQ-033 req1 group, engine returns only 3 of 4 outputs -> err_timeout = 1 exactly TIMEOUT idle cycles after the last out_valid; FSM returns to IDLE; next group is granted normally.
REQ-034 Reset pulled low after 2 of 4 group0 inputs -> next cycle state IDLE, counters 0, outputs 0; a stray cte_out_valid is not forwarded.
